alu_sequencer: RTL and testbench

//  Command-side initiator for the alu block. Accepts one operation per valid/ready handshake,

---
 rtl/alu_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command per handshake, drives the attached alu,
// gates execution on a C/N/P/Z predicate, and returns the result and flags.
module alu_sequencer #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [MAX_WIDTH-1:0] cmd_a,
    input  logic [MAX_WIDTH-1:0] cmd_b,
    input  logic [2:0]           cmd_op,
    input  logic [1:0]           cmd_shamt,
    input  logic                 cmd_setf,
    input  logic [2:0]           cmd_cond,
    output logic [MAX_WIDTH-1:0] busA,
    output logic [MAX_WIDTH-1:0] busB,
    output logic [2:0]           selop,
    output logic [1:0]           shamt,
    output logic                 enaf,
    input  logic [MAX_WIDTH-1:0] busC,
    input  logic                 C,
    input  logic                 N,
    input  logic                 P,
    input  logic                 Z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MAX_WIDTH-1:0] rsp_data,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_skip,
    output logic [CNT_W-1:0]     ops_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Execute predicate over the flags as they stand before the operation.
    function automatic logic pred_eval(input logic [2:0] cond,
                                       input logic c, input logic n,
                                       input logic p, input logic z);
        logic r;
        case (cond)
            3'b000:  r = 1'b1;
            3'b001:  r = z;
            3'b010:  r = ~z;
            3'b011:  r = c;
            3'b100:  r = ~c;
            3'b101:  r = n;
            3'b110:  r = p;
            3'b111:  r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [MAX_WIDTH-1:0]  bus_a_q, bus_a_d;
    logic [MAX_WIDTH-1:0]  bus_b_q, bus_b_d;
    logic [2:0]            selop_q, selop_d;
    logic [1:0]            shamt_q, shamt_d;
    logic                  enaf_q, enaf_d;
    logic                  pred_q, pred_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [MAX_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [3:0]            rsp_flags_q, rsp_flags_d;
    logic                  rsp_skip_q, rsp_skip_d;
    logic [CNT_W-1:0]      ops_done_q, ops_done_d;
    logic                  pred_now_s;

    // Predicate is resolved at accept time: the flags cannot change before ISSUE,
    // which lets enaf come straight from a flop during the ISSUE cycle.
    assign pred_now_s = pred_eval(cmd_cond, C, N, P, Z);

    // Next-state and next-output logic for the IDLE/ISSUE/SETTLE/RESP sequence.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        bus_a_d     = bus_a_q;
        bus_b_d     = bus_b_q;
        selop_d     = selop_q;
        shamt_d     = shamt_q;
        enaf_d      = 1'b0;
        pred_d      = pred_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_skip_d  = rsp_skip_q;
        ops_done_d  = ops_done_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ISSUE;
                    cmd_ready_d = 1'b0;
                    bus_a_d     = cmd_a;
                    bus_b_d     = cmd_b;
                    selop_d     = cmd_op;
                    shamt_d     = cmd_shamt;
                    pred_d      = pred_now_s;
                    enaf_d      = cmd_setf & pred_now_s;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d    = SETTLE;
                rsp_skip_d = ~pred_q;
                if (pred_q) begin
                    rsp_data_d = busC;
                    ops_done_d = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    rsp_data_d = {MAX_WIDTH{1'b0}};
                end
            end
            SETTLE: begin
                // Flag register in the alu has taken its update at the previous edge.
                state_d     = RESP;
                rsp_flags_d = {C, N, P, Z};
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight command at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            bus_a_q     <= {MAX_WIDTH{1'b0}};
            bus_b_q     <= {MAX_WIDTH{1'b0}};
            selop_q     <= 3'b000;
            shamt_q     <= 2'b00;
            enaf_q      <= 1'b0;
            pred_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {MAX_WIDTH{1'b0}};
            rsp_flags_q <= 4'b0000;
            rsp_skip_q  <= 1'b0;
            ops_done_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            bus_a_q     <= bus_a_d;
            bus_b_q     <= bus_b_d;
            selop_q     <= selop_d;
            shamt_q     <= shamt_d;
            enaf_q      <= enaf_d;
            pred_q      <= pred_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_skip_q  <= rsp_skip_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busA      = bus_a_q;
    assign busB      = bus_b_q;
    assign selop     = selop_q;
    assign shamt     = shamt_q;
    assign enaf      = enaf_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_skip  = rsp_skip_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small alu stub
// (busC = busA + busB, flag register loads a bench-chosen value when enaf=1).
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [1:0] cmd_shamt;
    logic       cmd_setf;
    logic [2:0] cmd_cond;
    logic [7:0] busA, busB, busC;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       enaf;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       rsp_skip;
    logic [3:0] ops_done;

    logic [3:0] flags_q;
    logic [3:0] fnext;
    logic [3:0] exp_ops;
    int         errors = 0;
    int         checks = 0;

    alu_sequencer #(.MAX_WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_shamt(cmd_shamt),
        .cmd_setf(cmd_setf), .cmd_cond(cmd_cond),
        .busA(busA), .busB(busB), .selop(selop), .shamt(shamt), .enaf(enaf),
        .busC(busC), .C(flags_q[3]), .N(flags_q[2]), .P(flags_q[1]), .Z(flags_q[0]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_skip(rsp_skip),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // alu stub: combinational result and flag register {C,N,P,Z}
    assign busC = busA + busB;
    always @(posedge clk or posedge rst) begin
        if (rst) flags_q <= 4'b0000;
        else if (enaf) flags_q <= fnext;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full command with checks at every stage; hold>0 applies response backpressure
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [1:0] sh, input logic setf, input logic [2:0] cond,
                           input logic e_enaf, input logic [7:0] e_data, input logic [3:0] e_flags,
                           input logic e_skip, input logic [3:0] e_ops, input int hold);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_shamt = sh;
        cmd_setf = setf; cmd_cond = cond; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_op = ~op; cmd_shamt = ~sh;
        chk("busA", busA, a);
        chk("busB", busB, b);
        chk("selop", selop, op);
        chk("shamt", shamt, sh);
        chk("enaf_issue", enaf, e_enaf);
        chk("cmd_ready_busy", cmd_ready, 1'b0);
        chk("rsp_valid_issue", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("enaf_settle", enaf, 1'b0);
        chk("rsp_valid_settle", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_flags", rsp_flags, e_flags);
        chk("rsp_skip", rsp_skip, e_skip);
        chk("ops_done", ops_done, e_ops);
        chk("enaf_resp", enaf, 1'b0);
        if (hold > 0) begin
            cmd_valid = 1'b1; cmd_a = 8'hEE; cmd_b = 8'hEE;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("bp_rsp_valid", rsp_valid, 1'b1);
                chk("bp_rsp_data", rsp_data, e_data);
                chk("bp_rsp_flags", rsp_flags, e_flags);
                chk("bp_rsp_skip", rsp_skip, e_skip);
                chk("bp_cmd_ready", cmd_ready, 1'b0);
                chk("bp_busA", busA, a);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_valid_done", rsp_valid, 1'b0);
        chk("cmd_ready_done", cmd_ready, 1'b1);
        chk("busA_hold", busA, a);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 3'b000; cmd_shamt = 2'b00;
        cmd_setf = 1'b0; cmd_cond = 3'b000; fnext = 4'b0000;
        #12;
        chk("rst_busA", busA, 8'h00);
        chk("rst_selop", selop, 3'b000);
        chk("rst_enaf", enaf, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_flags", rsp_flags, 4'b0000);
        chk("rst_ops_done", ops_done, 4'h0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        // basic op
        fnext = 4'b0001;
        run_cmd(8'h0F, 8'h01, 3'b000, 2'b00, 1'b1, 3'b000, 1'b1, 8'h10, 4'b0001, 1'b0, 4'd1, 0);
        // set P flag
        fnext = 4'b0010;
        run_cmd(8'h01, 8'h02, 3'b000, 2'b00, 1'b1, 3'b000, 1'b1, 8'h03, 4'b0010, 1'b0, 4'd2, 0);
        // skip: Z=0, cond Z
        fnext = 4'b1111;
        run_cmd(8'h33, 8'h44, 3'b001, 2'b10, 1'b1, 3'b001, 1'b0, 8'h00, 4'b0010, 1'b1, 4'd2, 0);
        // cond P true, result wraps to zero
        fnext = 4'b1000;
        run_cmd(8'h80, 8'h80, 3'b101, 2'b11, 1'b1, 3'b110, 1'b1, 8'h00, 4'b1000, 1'b0, 4'd3, 0);
        // cond !C with C=1 skips
        fnext = 4'b0111;
        run_cmd(8'h11, 8'h22, 3'b011, 2'b01, 1'b1, 3'b100, 1'b0, 8'h00, 4'b1000, 1'b1, 4'd3, 0);
        // setf=0: result returned, flags untouched
        run_cmd(8'hA0, 8'h05, 3'b010, 2'b01, 1'b0, 3'b000, 1'b0, 8'hA5, 4'b1000, 1'b0, 4'd4, 0);
        // cond C true
        fnext = 4'b0100;
        run_cmd(8'h12, 8'h34, 3'b110, 2'b00, 1'b1, 3'b011, 1'b1, 8'h46, 4'b0100, 1'b0, 4'd5, 0);
        // cond N true, setf=0, with 5 cycles of backpressure
        run_cmd(8'hFF, 8'h01, 3'b111, 2'b10, 1'b0, 3'b101, 1'b0, 8'h00, 4'b0100, 1'b0, 4'd6, 5);
        // never
        run_cmd(8'h01, 8'h01, 3'b000, 2'b00, 1'b1, 3'b111, 1'b0, 8'h00, 4'b0100, 1'b1, 4'd6, 0);
        // !Z with Z=0 executes, then !Z with Z=1 skips
        fnext = 4'b0001;
        run_cmd(8'h03, 8'h04, 3'b000, 2'b00, 1'b1, 3'b010, 1'b1, 8'h07, 4'b0001, 1'b0, 4'd7, 0);
        run_cmd(8'h03, 8'h04, 3'b000, 2'b00, 1'b1, 3'b010, 1'b0, 8'h00, 4'b0001, 1'b1, 4'd7, 0);

        // counter wrap: 16 executed ops bring a 4-bit counter back to 7; skips do not count
        exp_ops = 4'd7;
        for (int i = 0; i < 16; i++) begin
            exp_ops = exp_ops + 4'd1;
            run_cmd(8'(i), 8'h10, 3'b000, 2'b00, 1'b0, 3'b000, 1'b0, 8'(i + 16), 4'b0001,
                    1'b0, exp_ops, 0);
            if (i % 4 == 1)
                run_cmd(8'h55, 8'h01, 3'b000, 2'b00, 1'b1, 3'b111, 1'b0, 8'h00, 4'b0001,
                        1'b1, exp_ops, 0);
        end
        chk("wrap_final", ops_done, 4'd7);

        // reset while a response is pending
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 8'h21; cmd_b = 8'h01; cmd_setf = 1'b0; cmd_cond = 3'b000;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("pre_rst_rsp_valid", rsp_valid, 1'b1);
        rst = 1'b1; #1;
        chk("async_rsp_valid", rsp_valid, 1'b0);
        chk("async_ops_done", ops_done, 4'h0);
        chk("async_busA", busA, 8'h00);
        @(negedge clk); rst = 1'b0;

        // reset mid-ISSUE with enaf high
        fnext = 4'b0010;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 8'h09; cmd_b = 8'h09; cmd_setf = 1'b1; cmd_cond = 3'b000;
        @(posedge clk); #1; cmd_valid = 1'b0;
        chk("issue_enaf", enaf, 1'b1);
        rst = 1'b1; #1;
        chk("async_enaf", enaf, 1'b0);
        chk("async_rsp_valid2", rsp_valid, 1'b0);
        chk("async_ops_done2", ops_done, 4'h0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("no_rsp_after_abort", rsp_valid, 1'b0);
        chk("no_flag_update", flags_q, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound on total simulation time
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
